id_stage: RTL and testbench

//  Decode/register-read stage of the 2-slot VLIW pipe; consumes the IF/ID bundle (16b ALU + 16b MEM instr).

---
 rtl/id_stage_pkg.sv | 54 +++++
 rtl/id_stage_if.sv | 30 +++
 rtl/id_stage_regfile.sv | 47 ++++
 rtl/id_stage.sv | 174 +++++++++++++++++
 tb/tb_id_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Shared definitions for the VLIW decode stage: widths, opcodes,
// instruction layout, ID/EX register layout and the pipeline bubble.
package id_stage_pkg;

    localparam int DATA_W = 32;
    localparam int NREGS  = 8;
    localparam int REG_AW = 3;

    // ALU-slot ops occupy 0..7, MEM-slot ops 8..9; everything else is illegal.
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_BRN  = 4'd6,
        OP_JMP  = 4'd7,
        OP_LW   = 4'd8,
        OP_SW   = 4'd9
    } op_e;

    // [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt; imm6 = {rt, lo}, imm12 = [11:0].
    typedef struct packed {
        op_e              op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [2:0]        lo;
    } instr_t;

    typedef struct packed {
        logic              is_branch;
        logic [3:0]        alu_op;
        logic [DATA_W-1:0] alu_a;
        logic [DATA_W-1:0] alu_b;
        logic [REG_AW-1:0] alu_rd;
        logic              alu_reg_write;
        logic [DATA_W-1:0] mem_base;
        logic [DATA_W-1:0] mem_off;
        logic [DATA_W-1:0] mem_store_data;
        logic [REG_AW-1:0] mem_rd;
        logic              mem_read;
        logic              mem_write;
    } id_ex_t;

    // All enables clear and aluOp = NOP; data fields zero so reset and bubble match.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] v);
        return {{(DATA_W-6){v[5]}}, v};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX bundle handed from the decode stage to the EX stage.
interface id_stage_if;

    logic                            p2_isBranch;
    logic [3:0]                      p2_aluOp;
    logic [id_stage_pkg::DATA_W-1:0] p2_alu_a;
    logic [id_stage_pkg::DATA_W-1:0] p2_alu_b;
    logic [2:0]                      p2_alu_rd;
    logic                            p2_alu_regWrite;
    logic [id_stage_pkg::DATA_W-1:0] p2_mem_base;
    logic [id_stage_pkg::DATA_W-1:0] p2_mem_off;
    logic [id_stage_pkg::DATA_W-1:0] p2_mem_storeData;
    logic [2:0]                      p2_mem_rd;
    logic                            p2_mem_read;
    logic                            p2_mem_write;
    logic [id_stage_pkg::DATA_W-1:0] pc_branchTarget;

    modport master (
        output p2_isBranch, p2_aluOp, p2_alu_a, p2_alu_b, p2_alu_rd, p2_alu_regWrite,
               p2_mem_base, p2_mem_off, p2_mem_storeData, p2_mem_rd, p2_mem_read,
               p2_mem_write, pc_branchTarget
    );

    modport slave (
        input  p2_isBranch, p2_aluOp, p2_alu_a, p2_alu_b, p2_alu_rd, p2_alu_regWrite,
               p2_mem_base, p2_mem_off, p2_mem_storeData, p2_mem_rd, p2_mem_read,
               p2_mem_write, pc_branchTarget
    );

endinterface

// File: rtl/id_stage_regfile.sv
// 8x32 register file: two write ports (port B wins on a collision),
// four asynchronous read ports that see same-cycle write data, r0 fixed at 0.
module regfile_2w4r
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_a,
    input  logic [REG_AW-1:0] wa_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              we_b,
    input  logic [REG_AW-1:0] wa_b,
    input  logic [DATA_W-1:0] wd_b,
    input  logic [REG_AW-1:0] raddr [4],
    output logic [DATA_W-1:0] rdata [4]
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Next register contents: port A first, then port B so it overrides; r0 pinned.
    // NOTE: start from the current contents so every path assigns regs_d and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (we_a) regs_d[wa_a] = wd_a;
        if (we_b) regs_d[wa_b] = wd_b;
        regs_d[0] = '0;
    end

    // Reads come from the next-state view, which gives write-through bypass for free.
    always_comb begin
        for (int i = 0; i < 4; i++) rdata[i] = regs_d[raddr[i]];
    end

    // Register storage.
    // NOTE: this array is small and architecturally must read 0 after reset, so it is reset
    //       explicitly; large RAM-style arrays would normally be left unreset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode / register-read stage of the 2-slot VLIW pipe: decodes both slots,
// detects illegal bundles and load-use hazards, resolves jumps and loads ID/EX.
module id_stage
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       p1_aluInstr,
    input  logic [15:0]       p1_memInstr,
    input  logic [DATA_W-1:0] p1_pc,
    input  logic              ex_branchTaken,
    input  logic              wb_alu_we,
    input  logic [2:0]        wb_alu_rd,
    input  logic [DATA_W-1:0] wb_alu_data,
    input  logic              wb_mem_we,
    input  logic [2:0]        wb_mem_rd,
    input  logic [DATA_W-1:0] wb_mem_data,
    output logic              pcWrite,
    output logic              p1_pipeline_regWrite,
    output logic              p1_flush,
    output logic              isJump,
    output logic [DATA_W-1:0] pc_jumpTarget,
    output logic              isException,
    id_stage_if.master        ex
);

    instr_t            alu_i, mem_i;
    logic [REG_AW-1:0] rf_raddr [4];
    logic [DATA_W-1:0] rf_rdata [4];

    id_ex_t            id_ex_d, id_ex_q, dec;
    logic [DATA_W-1:0] pc_branch_target_d, pc_branch_target_q;

    logic alu_uses_rs, alu_uses_rt, alu_writes, alu_illegal, alu_is_jmp;
    logic mem_uses_rs, mem_uses_rt, mem_writes, mem_illegal;
    logic illegal, load_use, stall, squash;

    assign alu_i = p1_aluInstr;
    assign mem_i = p1_memInstr;

    // Read ports: 0/1 serve the ALU slot, 2/3 the MEM slot.
    always_comb begin
        rf_raddr[0] = alu_i.rs;
        rf_raddr[1] = alu_i.rt;
        rf_raddr[2] = mem_i.rs;
        rf_raddr[3] = mem_i.rt;
    end

    // The MEM writeback port is wired to port B so it wins a same-register collision.
    regfile_2w4r u_regfile (
        .clk   (clk),
        .reset (reset),
        .we_a  (wb_alu_we),
        .wa_a  (wb_alu_rd),
        .wd_a  (wb_alu_data),
        .we_b  (wb_mem_we),
        .wa_b  (wb_mem_rd),
        .wd_b  (wb_mem_data),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    // Per-slot decode: source usage, destination writes, legality and ID/EX payload.
    always_comb begin
        dec         = ID_EX_BUBBLE;
        alu_uses_rs = 1'b0;
        alu_uses_rt = 1'b0;
        alu_writes  = 1'b0;
        alu_illegal = 1'b0;
        alu_is_jmp  = 1'b0;
        mem_uses_rs = 1'b0;
        mem_uses_rt = 1'b0;
        mem_writes  = 1'b0;
        mem_illegal = 1'b0;

        case (alu_i.op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                alu_uses_rs       = 1'b1;
                alu_uses_rt       = (alu_i.op != OP_ADDI);
                alu_writes        = 1'b1;
                dec.alu_op        = (alu_i.op == OP_ADDI) ? OP_ADD : alu_i.op;
                dec.alu_a         = rf_rdata[0];
                dec.alu_b         = (alu_i.op == OP_ADDI) ? sext6({alu_i.rt, alu_i.lo}) : rf_rdata[1];
                dec.alu_rd        = alu_i.rd;
                dec.alu_reg_write = (alu_i.rd != '0);
            end
            OP_BRN: begin
                alu_uses_rs   = 1'b1;
                alu_uses_rt   = 1'b1;
                dec.alu_op    = OP_SUB;
                dec.alu_a     = rf_rdata[0];
                dec.alu_b     = rf_rdata[1];
                dec.is_branch = 1'b1;
            end
            OP_JMP:  alu_is_jmp  = 1'b1;
            default: alu_illegal = 1'b1;
        endcase

        case (mem_i.op)
            OP_NOP: ;
            OP_LW: begin
                mem_uses_rs  = 1'b1;
                mem_writes   = 1'b1;
                dec.mem_base = rf_rdata[2];
                dec.mem_off  = sext6({mem_i.rt, mem_i.lo});
                dec.mem_rd   = mem_i.rd;
                dec.mem_read = (mem_i.rd != '0);
            end
            OP_SW: begin
                mem_uses_rs        = 1'b1;
                mem_uses_rt        = 1'b1;
                dec.mem_base       = rf_rdata[2];
                dec.mem_off        = sext6({mem_i.rt, mem_i.lo});
                dec.mem_store_data = rf_rdata[3];
                dec.mem_write      = 1'b1;
            end
            default: mem_illegal = 1'b1;
        endcase
    end

    // Hazard priority (taken branch > illegal > load-use > jump), IF control and ID/EX next state.
    always_comb begin
        illegal = alu_illegal || mem_illegal ||
                  (alu_writes && mem_writes && alu_i.rd == mem_i.rd && alu_i.rd != '0);

        load_use = id_ex_q.mem_read && (id_ex_q.mem_rd != '0) &&
                   ((alu_uses_rs && alu_i.rs == id_ex_q.mem_rd) ||
                    (alu_uses_rt && alu_i.rt == id_ex_q.mem_rd) ||
                    (mem_uses_rs && mem_i.rs == id_ex_q.mem_rd) ||
                    (mem_uses_rt && mem_i.rt == id_ex_q.mem_rd));

        stall  = load_use && !ex_branchTaken && !illegal;
        squash = ex_branchTaken || illegal || stall;

        isException          = illegal && !ex_branchTaken;
        isJump               = alu_is_jmp && !ex_branchTaken && !illegal && !stall;
        pc_jumpTarget        = {p1_pc[DATA_W-1:14], p1_aluInstr[11:0], 2'b00};
        pcWrite              = !stall;
        p1_pipeline_regWrite = !stall;
        p1_flush             = ex_branchTaken || illegal || isJump;

        id_ex_d            = squash ? ID_EX_BUBBLE : dec;
        pc_branch_target_d = pc_branch_target_q;
        if (!squash && dec.is_branch)
            pc_branch_target_d = p1_pc + (sext6({alu_i.rt, alu_i.lo}) << 2);
    end

    // ID/EX pipeline register and the branch target that travels with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_q            <= ID_EX_BUBBLE;
            pc_branch_target_q <= '0;
        end else begin
            id_ex_q            <= id_ex_d;
            pc_branch_target_q <= pc_branch_target_d;
        end
    end

    assign ex.p2_isBranch      = id_ex_q.is_branch;
    assign ex.p2_aluOp         = id_ex_q.alu_op;
    assign ex.p2_alu_a         = id_ex_q.alu_a;
    assign ex.p2_alu_b         = id_ex_q.alu_b;
    assign ex.p2_alu_rd        = id_ex_q.alu_rd;
    assign ex.p2_alu_regWrite  = id_ex_q.alu_reg_write;
    assign ex.p2_mem_base      = id_ex_q.mem_base;
    assign ex.p2_mem_off       = id_ex_q.mem_off;
    assign ex.p2_mem_storeData = id_ex_q.mem_store_data;
    assign ex.p2_mem_rd        = id_ex_q.mem_rd;
    assign ex.p2_mem_read      = id_ex_q.mem_read;
    assign ex.p2_mem_write     = id_ex_q.mem_write;
    assign ex.pc_branchTarget  = pc_branch_target_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: reset, operand read and bypass, load-use
// stall, branch, jump, illegal bundles and asynchronous reset during a stall.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] p1_aluInstr, p1_memInstr;
    logic [31:0] p1_pc;
    logic        ex_branchTaken;
    logic        wb_alu_we, wb_mem_we;
    logic [2:0]  wb_alu_rd, wb_mem_rd;
    logic [31:0] wb_alu_data, wb_mem_data;
    logic        pcWrite, p1_pipeline_regWrite, p1_flush, isJump, isException;
    logic [31:0] pc_jumpTarget;

    int errors = 0;
    int checks = 0;

    id_stage_if ex_if ();

    id_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .p1_aluInstr          (p1_aluInstr),
        .p1_memInstr          (p1_memInstr),
        .p1_pc                (p1_pc),
        .ex_branchTaken       (ex_branchTaken),
        .wb_alu_we            (wb_alu_we),
        .wb_alu_rd            (wb_alu_rd),
        .wb_alu_data          (wb_alu_data),
        .wb_mem_we            (wb_mem_we),
        .wb_mem_rd            (wb_mem_rd),
        .wb_mem_data          (wb_mem_data),
        .pcWrite              (pcWrite),
        .p1_pipeline_regWrite (p1_pipeline_regWrite),
        .p1_flush             (p1_flush),
        .isJump               (isJump),
        .pc_jumpTarget        (pc_jumpTarget),
        .isException          (isException),
        .ex                   (ex_if)
    );

    always #5 clk = ~clk;

    // Safety net in case the run never reaches its summary.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [5:0] low);
        return {op, rd, rs, low};
    endfunction

    initial begin
        reset = 1'b1;
        p1_aluInstr = '0; p1_memInstr = '0; p1_pc = '0; ex_branchTaken = 1'b0;
        wb_alu_we = 1'b0; wb_alu_rd = '0; wb_alu_data = '0;
        wb_mem_we = 1'b0; wb_mem_rd = '0; wb_mem_data = '0;

        // Reset state
        #2;
        check("rst_alu_regWrite", ex_if.p2_alu_regWrite, 0);
        check("rst_mem_read", ex_if.p2_mem_read, 0);
        check("rst_isBranch", ex_if.p2_isBranch, 0);
        check("rst_branchTarget", ex_if.pc_branchTarget, 0);
        check("rst_pcWrite", pcWrite, 1);
        check("rst_ifid_we", p1_pipeline_regWrite, 1);
        check("rst_flush", p1_flush, 0);
        check("rst_exception", isException, 0);
        #10 reset = 1'b0;
        tick();

        // 1: r1=5 (ALU port), r2=3 (MEM port); then ADD r3,r1,r2 | NOP
        wb_alu_we = 1; wb_alu_rd = 1; wb_alu_data = 5;
        wb_mem_we = 1; wb_mem_rd = 2; wb_mem_data = 3;
        tick();
        wb_alu_we = 0; wb_mem_we = 0;
        p1_aluInstr = ins(4'd1, 3'd3, 3'd1, {3'd2, 3'd0});
        tick();
        check("add_a", ex_if.p2_alu_a, 5);
        check("add_b", ex_if.p2_alu_b, 3);
        check("add_rd", ex_if.p2_alu_rd, 3);
        check("add_we", ex_if.p2_alu_regWrite, 1);
        check("add_op", ex_if.p2_aluOp, 1);

        // 2: LW r4,0(r1) then ADD r5,r4,r1 -> one-cycle stall
        p1_aluInstr = '0;
        p1_memInstr = ins(4'd8, 3'd4, 3'd1, 6'd0);
        tick();
        check("lw_read", ex_if.p2_mem_read, 1);
        check("lw_rd", ex_if.p2_mem_rd, 4);
        check("lw_base", ex_if.p2_mem_base, 5);
        p1_memInstr = '0;
        p1_aluInstr = ins(4'd1, 3'd5, 3'd4, {3'd1, 3'd0});
        #2;
        check("stall_pcWrite", pcWrite, 0);
        check("stall_ifid_we", p1_pipeline_regWrite, 0);
        tick();
        check("stall_bubble_we", ex_if.p2_alu_regWrite, 0);
        check("stall_bubble_op", ex_if.p2_aluOp, 0);
        check("stall_bubble_read", ex_if.p2_mem_read, 0);
        wb_mem_we = 1; wb_mem_rd = 4; wb_mem_data = 32'h20;
        #2;
        check("post_stall_pcWrite", pcWrite, 1);
        tick();
        wb_mem_we = 0;
        check("post_stall_a", ex_if.p2_alu_a, 32'h20);
        check("post_stall_b", ex_if.p2_alu_b, 5);
        check("post_stall_rd", ex_if.p2_alu_rd, 5);
        check("post_stall_we", ex_if.p2_alu_regWrite, 1);

        // 3: write-through bypass and MEM-port priority
        wb_alu_we = 1; wb_alu_rd = 2; wb_alu_data = 7;
        p1_aluInstr = ins(4'd1, 3'd6, 3'd1, {3'd2, 3'd0});
        tick();
        check("bypass_a", ex_if.p2_alu_a, 5);
        check("bypass_b", ex_if.p2_alu_b, 7);
        wb_alu_we = 1; wb_alu_rd = 2; wb_alu_data = 1;
        wb_mem_we = 1; wb_mem_rd = 2; wb_mem_data = 9;
        p1_aluInstr = ins(4'd1, 3'd6, 3'd2, {3'd0, 3'd0});
        tick();
        check("both_wb_bypass", ex_if.p2_alu_a, 9);
        check("r0_reads_zero", ex_if.p2_alu_b, 0);
        wb_alu_we = 0; wb_mem_we = 0;
        tick();
        check("both_wb_stored", ex_if.p2_alu_a, 9);

        // 4: BRN r1,r7,-2 at pc 0x100, then taken branch from EX
        p1_pc = 32'h100;
        p1_aluInstr = ins(4'd6, 3'd0, 3'd1, 6'b111110);
        tick();
        check("brn_isBranch", ex_if.p2_isBranch, 1);
        check("brn_op", ex_if.p2_aluOp, 2);
        check("brn_a", ex_if.p2_alu_a, 5);
        check("brn_we", ex_if.p2_alu_regWrite, 0);
        check("brn_target", ex_if.pc_branchTarget, 32'hF8);
        p1_aluInstr = ins(4'd1, 3'd3, 3'd1, {3'd2, 3'd0});
        p1_memInstr = 16'hF000;
        ex_branchTaken = 1;
        #2;
        check("taken_flush", p1_flush, 1);
        check("taken_pcWrite", pcWrite, 1);
        check("taken_no_exception", isException, 0);
        tick();
        ex_branchTaken = 0;
        p1_memInstr = '0;
        check("taken_bubble_br", ex_if.p2_isBranch, 0);
        check("taken_bubble_we", ex_if.p2_alu_regWrite, 0);

        // 5: JMP 0x123 at pc 0x4000_0010 with LW in MEM slot; then JMP while stalled
        p1_pc = 32'h4000_0010;
        p1_aluInstr = {4'd7, 12'h123};
        p1_memInstr = ins(4'd8, 3'd6, 3'd1, 6'd4);
        #2;
        check("jmp_isJump", isJump, 1);
        check("jmp_target", pc_jumpTarget, 32'h4000_048C);
        check("jmp_flush", p1_flush, 1);
        check("jmp_pcWrite", pcWrite, 1);
        tick();
        check("jmp_alu_nop", ex_if.p2_aluOp, 0);
        check("jmp_alu_we", ex_if.p2_alu_regWrite, 0);
        check("jmp_mem_read", ex_if.p2_mem_read, 1);
        check("jmp_mem_rd", ex_if.p2_mem_rd, 6);
        check("jmp_mem_off", ex_if.p2_mem_off, 4);
        p1_memInstr = ins(4'd9, 3'd0, 3'd6, {3'd2, 3'd0});
        #2;
        check("jmp_stall_isJump", isJump, 0);
        check("jmp_stall_pcWrite", pcWrite, 0);
        check("jmp_stall_flush", p1_flush, 0);
        tick();
        check("jmp_stall_bubble", ex_if.p2_mem_write, 0);
        #2;
        check("jmp_retry_isJump", isJump, 1);
        tick();
        check("sw_write", ex_if.p2_mem_write, 1);
        check("sw_data", ex_if.p2_mem_storeData, 9);
        check("sw_base", ex_if.p2_mem_base, 0);

        // 6: illegal MEM opcode, then same-rd conflict ADD r3 | LW r3
        p1_pc = 32'h200;
        p1_aluInstr = ins(4'd1, 3'd3, 3'd1, {3'd2, 3'd0});
        p1_memInstr = 16'hF000;
        #2;
        check("illop_exception", isException, 1);
        check("illop_flush", p1_flush, 1);
        check("illop_pcWrite", pcWrite, 1);
        tick();
        check("illop_bubble_we", ex_if.p2_alu_regWrite, 0);
        check("illop_bubble_wr", ex_if.p2_mem_write, 0);
        p1_memInstr = ins(4'd8, 3'd3, 3'd1, 6'd0);
        #2;
        check("samerd_exception", isException, 1);
        tick();
        check("samerd_bubble_read", ex_if.p2_mem_read, 0);
        check("samerd_bubble_we", ex_if.p2_alu_regWrite, 0);

        // Async reset while stalled
        p1_aluInstr = '0;
        p1_memInstr = ins(4'd8, 3'd4, 3'd1, 6'd0);
        tick();
        check("rs_lw_read", ex_if.p2_mem_read, 1);
        p1_memInstr = '0;
        p1_aluInstr = ins(4'd1, 3'd5, 3'd4, {3'd1, 3'd0});
        #2;
        check("rs_stalled", pcWrite, 0);
        #1 reset = 1'b1;
        #1;
        check("rs_mem_read", ex_if.p2_mem_read, 0);
        check("rs_mem_rd", ex_if.p2_mem_rd, 0);
        check("rs_mem_base", ex_if.p2_mem_base, 0);
        check("rs_pcWrite", pcWrite, 1);
        #1 reset = 1'b0;
        tick();
        check("rs_issue_we", ex_if.p2_alu_regWrite, 1);
        check("rs_issue_rd", ex_if.p2_alu_rd, 5);
        check("rs_issue_a", ex_if.p2_alu_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
